// File: rtl/polygon_vertex_loader.sv
// polygon_vertex_loader
//
// Producer side of the vertex-array interface for the point-in-polygon tester.
// Vertices arrive one per valid/ready beat and are assembled in a shadow bank.
// A polygon with 3..MAX_NUM_VERTICES vertices waits in PENDING. It is copied
// to the active bank on the next new_frame_in, so the arrays the pixel
// pipeline reads stay stable for a whole frame.
//
// Ports:
//   clk_in          system clock, all logic on the rising edge
//   rst_in          synchronous active-high reset
//   new_frame_in    single-cycle frame-start pulse
//   x_in, y_in      vertex coordinates (signed pixel units)
//   valid_in        vertex beat valid
//   last_in         final vertex of the polygon (qualified by valid_in)
//   ready_out       loader can accept a beat (registered)
//   xs_out, ys_out  active vertex arrays
//   num_points_out  active vertex count
//   commit_out      one-cycle pulse when the active bank was updated
//   error_out       one-cycle pulse when a polygon was rejected
module polygon_vertex_loader #(
    parameter int PIXEL_WIDTH      = 1280,
    parameter int PIXEL_HEIGHT     = 720,
    parameter int MAX_NUM_VERTICES = 32
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      new_frame_in,
    input  logic signed [31:0]                        x_in,
    input  logic signed [31:0]                        y_in,
    input  logic                                      valid_in,
    input  logic                                      last_in,
    output logic                                      ready_out,
    output logic signed [31:0]                        xs_out [MAX_NUM_VERTICES],
    output logic signed [31:0]                        ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]     num_points_out,
    output logic                                      commit_out,
    output logic                                      error_out
);

    localparam int IDX_W  = $clog2(MAX_NUM_VERTICES + 1);
    localparam int ADDR_W = $clog2(MAX_NUM_VERTICES);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_NUM_VERTICES);
    localparam logic [IDX_W-1:0] MIN_IDX = IDX_W'(3);

    // The resolution parameters only exist to match the downstream pixel
    // logic; a non-positive resolution leaves an obviously named empty scope.
    if (PIXEL_WIDTH <= 0 || PIXEL_HEIGHT <= 0) begin : g_bad_resolution
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DISCARD,
        CHECK,
        PENDING
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   index_reg, index_next;
    logic [IDX_W-1:0]   pending_reg, pending_next;
    logic               error_next, commit_next, ready_next;
    logic               beat;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;

    logic signed [31:0] shadow_x [MAX_NUM_VERTICES];
    logic signed [31:0] shadow_y [MAX_NUM_VERTICES];

    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        pending_next = pending_reg;
        error_next   = 1'b0;
        commit_next  = 1'b0;
        wr_en        = 1'b0;
        // IDLE always starts a polygon at slot 0, whatever index was left over.
        wr_addr      = (state_reg == IDLE) ? '0 : index_reg[ADDR_W-1:0];
        beat         = valid_in && ready_out;

        case (state_reg)
            IDLE: begin
                if (beat) begin
                    wr_en      = 1'b1;
                    index_next = IDX_W'(1);
                    state_next = last_in ? CHECK : LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    if (index_reg == MAX_IDX) begin
                        // Bank full: a closing beat rejects now, anything else
                        // drains the rest of the polygon.
                        if (last_in) begin
                            error_next = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = DISCARD;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        index_next = index_reg + IDX_W'(1);
                        if (last_in) begin
                            state_next = CHECK;
                        end
                    end
                end
            end
            DISCARD: begin
                if (beat && last_in) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                // index already counts the vertices written.
                if (index_reg < MIN_IDX) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    pending_next = index_reg;
                    state_next   = PENDING;
                end
            end
            PENDING: begin
                if (new_frame_in) begin
                    commit_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        ready_next = (state_next == IDLE) || (state_next == LOAD) ||
                     (state_next == DISCARD);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= IDLE;
            index_reg      <= '0;
            pending_reg    <= '0;
            ready_out      <= 1'b1;
            error_out      <= 1'b0;
            commit_out     <= 1'b0;
            num_points_out <= '0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            pending_reg <= pending_next;
            ready_out   <= ready_next;
            error_out   <= error_next;
            commit_out  <= commit_next;
            if (commit_next) begin
                num_points_out <= pending_reg;
            end
        end
    end

    // Shadow bank: no reset needed, only slots below the committed count matter.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            shadow_x[wr_addr] <= x_in;
            shadow_y[wr_addr] <= y_in;
        end
    end

    // Active bank: whole-bank copy on commit, so every slot is its own register.
    genvar gi;
    for (gi = 0; gi < MAX_NUM_VERTICES; gi++) begin : g_active
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                xs_out[gi] <= '0;
                ys_out[gi] <= '0;
            end else if (commit_next) begin
                xs_out[gi] <= shadow_x[gi];
                ys_out[gi] <= shadow_y[gi];
            end
        end
    end

endmodule
